// File: rtl/discrete_audio_pkg.sv
// Shared types, limits and saturation helpers for the discrete audio mixer.
package discrete_audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam sample_t SAMPLE_MAX = 16'sd32767;
    localparam sample_t SAMPLE_MIN = -16'sd32768;

    // Wide copies of the limits so comparisons stay in the accumulator domain.
    localparam logic signed [47:0] WIDE_MAX = 48'sd32767;
    localparam logic signed [47:0] WIDE_MIN = -48'sd32768;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } mixer_state_t;

    function automatic sample_t saturate_16(input logic signed [47:0] v);
        if (v > WIDE_MAX) begin
            return SAMPLE_MAX;
        end else if (v < WIDE_MIN) begin
            return SAMPLE_MIN;
        end
        return $signed(v[15:0]);
    endfunction

    function automatic logic is_clipped(input logic signed [47:0] v);
        return (v > WIDE_MAX) || (v < WIDE_MIN);
    endfunction

endpackage

// File: rtl/discrete_mac.sv
// Registered signed x unsigned multiply-accumulate with synchronous clear.
// One cycle per product; clear has priority over accumulate.
module discrete_mac #(
    parameter int ACC_W = 35
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [15:0]      i_a,
    input  logic [15:0]             i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [32:0]      w_a_ext;
    logic signed [32:0]      w_b_ext;
    logic signed [32:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] r_acc;

    // Gain is zero-extended so the full 0..65535 range stays positive.
    assign w_a_ext    = {{17{i_a[15]}}, i_a};
    assign w_b_ext    = {17'b0, i_b};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/discrete_audio_mixer.sv
// Mixes NUM_CHANNELS gain-scaled samples into one saturated sample per audio tick via one shared MAC.
// Latency NUM_CHANNELS+2 cycles; optional clip counter under DISCRETE_MIXER_CLIP_COUNT_EN.
module discrete_audio_mixer
    import discrete_audio_pkg::*;
#(
    parameter int CLOCK_RATE     = 50000000,
    parameter int SAMPLE_RATE    = 48000,
    parameter int NUM_CHANNELS   = 4,
    parameter int GAIN_FRAC_BITS = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_audio_clk_en,
    input  logic [16*NUM_CHANNELS-1:0]  i_in,
    input  logic [16*NUM_CHANNELS-1:0]  i_gain,
    output sample_t                     o_out,
    output logic                        o_out_valid
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    ,
    output logic [15:0]                 o_clip_count
`endif
);

    localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int ACC_W  = 33 + $clog2(NUM_CHANNELS);
    localparam int DATA_W = 16 * NUM_CHANNELS;

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
        $error("discrete_audio_mixer: NUM_CHANNELS must be 1..16");
    end
    if (CLOCK_RATE / SAMPLE_RATE < NUM_CHANNELS + 2) begin : g_bad_rate
        $error("discrete_audio_mixer: too few clock cycles per audio sample");
    end

    mixer_state_t            r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_W-1:0]       r_snap_in;
    logic [DATA_W-1:0]       r_snap_gain;
    sample_t                 r_out;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [15:0]      w_sel_in;
    logic [15:0]             w_sel_gain;
    logic signed [47:0]      w_shifted;
    logic                    w_last;
    logic                    w_commit;

    assign w_sel_in   = $signed(r_snap_in[{r_idx, 4'b0000} +: 16]);
    assign w_sel_gain = r_snap_gain[{r_idx, 4'b0000} +: 16];
    assign w_shifted  = 48'(w_acc) >>> GAIN_FRAC_BITS;
    assign w_last     = (r_idx == IDX_W'(NUM_CHANNELS - 1));
    // A tick landing in SAT aborts that sample, so the commit is masked by it.
    assign w_commit   = (r_state == SAT) && !i_audio_clk_en && !i_reset;

    discrete_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_audio_clk_en),
        .i_en    (r_state == ACCUM),
        .i_a     (w_sel_in),
        .i_b     (w_sel_gain),
        .o_acc   (w_acc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_snap_in   <= '0;
            r_snap_gain <= '0;
            r_out       <= '0;
        end else if (i_audio_clk_en) begin
            r_state     <= ACCUM;
            r_idx       <= '0;
            r_snap_in   <= i_in;
            r_snap_gain <= i_gain;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_last) begin
                        r_state <= SAT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                SAT: begin
                    r_out   <= saturate_16(w_shifted);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    logic [15:0] r_clip_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clip_count <= '0;
        end else if (w_commit && is_clipped(w_shifted) && (r_clip_count != 16'hFFFF)) begin
            r_clip_count <= r_clip_count + 16'd1;
        end
    end

    assign o_clip_count = r_clip_count;
`endif

    assign o_out       = r_out;
    assign o_out_valid = w_commit;

endmodule
